// File: rtl/digit_serial_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
//   t_dsa_state     : controller state (IDLE, RUN, DONE)
//   DSA_DIGIT_WIDTH : default digit width in bits
//   dsa_num_digits  : digits per operand
//   dsa_cnt_width   : digit counter width, never below 1
package digit_serial_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } t_dsa_state;

   localparam int unsigned DSA_DIGIT_WIDTH = 2;

   function automatic int unsigned dsa_num_digits(input int unsigned data_w,
                                                  input int unsigned digit_w);
      // A zero digit width is rejected separately; avoid dividing by it here.
      return (digit_w == 0) ? 1 : data_w / digit_w;
   endfunction

   function automatic int unsigned dsa_cnt_width(input int unsigned data_w,
                                                 input int unsigned digit_w);
      int unsigned n;
      n = dsa_num_digits(data_w, digit_w);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/full_adder.sv
// Combinational multi-bit adder with carry-in and carry-out.
//   i_a, i_b : DATA_WIDTH-bit addends
//   i_cin    : carry-in
//   o_sum    : DATA_WIDTH-bit sum
//   o_cout   : carry-out
module full_adder #(
   parameter int unsigned DATA_WIDTH = 2
) (
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic                  i_cin,
   output logic [DATA_WIDTH-1:0] o_sum,
   output logic                  o_cout
);

   logic [DATA_WIDTH:0] total;

   always_comb begin
      total  = {1'b0, i_a} + {1'b0, i_b} + {{DATA_WIDTH{1'b0}}, i_cin};
      o_sum  = total[DATA_WIDTH-1:0];
      o_cout = total[DATA_WIDTH];
   end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder controller: accepts two operands and a carry-in,
// adds them LSB-first one digit per cycle through a single full_adder,
// then presents sum and carry-out until the consumer takes them.
//   i_clk, i_arst            : clock, asynchronous active-high reset
//   i_valid / o_ready        : operand handshake
//   i_operand1, i_operand2   : DATA_WIDTH-bit addends
//   i_cin                    : carry-in to the least-significant digit
//   o_valid / i_ready        : result handshake
//   o_sum, o_cout            : sum modulo 2^DATA_WIDTH and final carry
module digit_serial_adder
   import digit_serial_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned DIGIT_WIDTH = DSA_DIGIT_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_operand1,
   input  logic [DATA_WIDTH-1:0] i_operand2,
   input  logic                  i_cin,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_sum,
   output logic                  o_cout
);

   localparam int unsigned NUM_DIGITS = dsa_num_digits(DATA_WIDTH, DIGIT_WIDTH);
   localparam int unsigned CNT_W      = dsa_cnt_width(DATA_WIDTH, DIGIT_WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

   if ((DIGIT_WIDTH == 0) ||
       ((DATA_WIDTH % ((DIGIT_WIDTH == 0) ? 1 : DIGIT_WIDTH)) != 0)) begin : g_bad_params
      $error("digit_serial_adder: DATA_WIDTH must be a non-zero multiple of DIGIT_WIDTH");
   end

   t_dsa_state            state_q, state_d;
   logic [DATA_WIDTH-1:0] op1_q, op1_d;
   logic [DATA_WIDTH-1:0] op2_q, op2_d;
   logic [DATA_WIDTH-1:0] sum_q, sum_d;
   logic                  carry_q, carry_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [DIGIT_WIDTH-1:0] fa_sum;
   logic                   fa_cout;

   full_adder #(
      .DATA_WIDTH(DIGIT_WIDTH)
   ) u_full_adder (
      .i_a   (op1_q[DIGIT_WIDTH-1:0]),
      .i_b   (op2_q[DIGIT_WIDTH-1:0]),
      .i_cin (carry_q),
      .o_sum (fa_sum),
      .o_cout(fa_cout)
   );

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q <= IDLE;
         op1_q   <= '0;
         op2_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      o_ready = 1'b0;
      o_valid = 1'b0;
      o_sum   = '0;
      o_cout  = 1'b0;

      case (state_q)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               op1_d   = i_operand1;
               op2_d   = i_operand2;
               carry_d = i_cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            op1_d = op1_q >> DIGIT_WIDTH;
            op2_d = op2_q >> DIGIT_WIDTH;
            // New digit enters at the top; after NUM_DIGITS shifts the
            // first digit has reached bit 0. Written as shift-then-insert so
            // the single-digit case needs no zero-width slice.
            sum_d = sum_q >> DIGIT_WIDTH;
            sum_d[DATA_WIDTH-1 -: DIGIT_WIDTH] = fa_sum;
            carry_d = fa_cout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            o_valid = 1'b1;
            o_sum   = sum_q;
            o_cout  = carry_q;
            if (i_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder at three geometries (16/2, 8/4, 2/2).
// A transaction-level model predicts handshake timing and results; a
// negedge process compares all three instances every cycle, and directed
// cases on the 16/2 instance pin literal results.
module tb_digit_serial_adder;

   logic clk  = 1'b0;
   logic arst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        vin [3];
   logic        cinv[3];
   logic        irdy[3];
   logic [15:0] opa [3];
   logic [15:0] opb [3];
   logic        ordy [3];
   logic        oval [3];
   logic        ocout[3];
   logic [15:0] osum [3];
   logic        rdone[3];

   logic [15:0] s0;
   logic [7:0]  s1;
   logic [1:0]  s2;
   logic        r0, r1, r2, v0, v1, v2, c0, c1, c2;

   digit_serial_adder #(.DATA_WIDTH(16), .DIGIT_WIDTH(2)) dut0 (
      .i_clk(clk), .i_arst(arst), .i_valid(vin[0]), .o_ready(r0),
      .i_operand1(opa[0]), .i_operand2(opb[0]), .i_cin(cinv[0]),
      .o_valid(v0), .i_ready(irdy[0]), .o_sum(s0), .o_cout(c0));

   digit_serial_adder #(.DATA_WIDTH(8), .DIGIT_WIDTH(4)) dut1 (
      .i_clk(clk), .i_arst(arst), .i_valid(vin[1]), .o_ready(r1),
      .i_operand1(opa[1][7:0]), .i_operand2(opb[1][7:0]), .i_cin(cinv[1]),
      .o_valid(v1), .i_ready(irdy[1]), .o_sum(s1), .o_cout(c1));

   digit_serial_adder #(.DATA_WIDTH(2), .DIGIT_WIDTH(2)) dut2 (
      .i_clk(clk), .i_arst(arst), .i_valid(vin[2]), .o_ready(r2),
      .i_operand1(opa[2][1:0]), .i_operand2(opb[2][1:0]), .i_cin(cinv[2]),
      .o_valid(v2), .i_ready(irdy[2]), .o_sum(s2), .o_cout(c2));

   always_comb begin
      ordy[0] = r0;  ordy[1] = r1;  ordy[2] = r2;
      oval[0] = v0;  oval[1] = v1;  oval[2] = v2;
      ocout[0] = c0; ocout[1] = c1; ocout[2] = c2;
      osum[0] = s0;
      osum[1] = {8'h00, s1};
      osum[2] = {14'h0000, s2};
   end

   function automatic int dw_of(input int k);
      return (k == 0) ? 16 : (k == 1) ? 8 : 2;
   endfunction

   function automatic int nd_of(input int k);
      return (k == 0) ? 8 : (k == 1) ? 2 : 1;
   endfunction

   // Plain-arithmetic reference: {cout, sum} = a + b + cin at width dw.
   function automatic logic [16:0] model_add(input int k, input logic [15:0] a,
                                             input logic [15:0] b, input logic c);
      logic [16:0] m;
      m = (17'h1 << dw_of(k)) - 17'h1;
      return ({1'b0, a} & m) + ({1'b0, b} & m) + {16'h0, c};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model state: busy from accept until the result is taken.
   logic        active[3];
   int          due   [3];
   logic [16:0] expv  [3];

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         logic        ev;
         logic [16:0] m;
         m  = (17'h1 << dw_of(k)) - 17'h1;
         ev = active[k] && (cyc >= due[k]);
         if (arst) begin
            check($sformatf("d%0d_rst_ready", k), {31'h0, ordy[k]}, 32'h1);
            check($sformatf("d%0d_rst_valid", k), {31'h0, oval[k]}, 32'h0);
            check($sformatf("d%0d_rst_sum", k), {16'h0, osum[k]}, 32'h0);
            check($sformatf("d%0d_rst_cout", k), {31'h0, ocout[k]}, 32'h0);
            active[k] <= 1'b0;
         end else begin
            check($sformatf("d%0d_ready", k), {31'h0, ordy[k]}, {31'h0, !active[k]});
            check($sformatf("d%0d_valid", k), {31'h0, oval[k]}, {31'h0, ev});
            if (ev) begin
               check($sformatf("d%0d_sum", k), {16'h0, osum[k]}, {15'h0, expv[k] & m});
               check($sformatf("d%0d_cout", k), {31'h0, ocout[k]},
                     {31'h0, expv[k][dw_of(k)]});
            end
            if (!active[k] && vin[k]) begin
               active[k] <= 1'b1;
               due[k]    <= cyc + 1 + nd_of(k);
               expv[k]   <= model_add(k, opa[k], opb[k], cinv[k]);
            end else if (ev && irdy[k]) begin
               active[k] <= 1'b0;
            end
         end
      end
   end

   task automatic wait_edge();
      @(posedge clk);
      #1;
   endtask

   // Present operands once the block is ready; returns just after the accept edge.
   task automatic send(input int k, input logic [15:0] a, input logic [15:0] b, input logic c);
      int n = 0;
      while (!ordy[k] && n < 100) begin
         wait_edge();
         n++;
      end
      check($sformatf("d%0d_send_ready", k), {31'h0, ordy[k]}, 32'h1);
      opa[k] = a; opb[k] = b; cinv[k] = c; vin[k] = 1'b1;
      wait_edge();
      vin[k] = 1'b0;
   endtask

   task automatic wait_valid(input int k, output int n);
      n = 0;
      while (!oval[k] && n < 100) begin
         wait_edge();
         n++;
      end
   endtask

   task automatic dir_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [15:0] es, input logic ec);
      int n;
      send(0, a, b, c);
      check({nm, "_busy"}, {31'h0, ordy[0]}, 32'h0);
      wait_valid(0, n);
      check({nm, "_latency"}, n, 8);
      check({nm, "_sum"}, {16'h0, osum[0]}, {16'h0, es});
      check({nm, "_cout"}, {31'h0, ocout[0]}, {31'h0, ec});
      irdy[0] = 1'b1;
      wait_edge();
      irdy[0] = 1'b0;
      check({nm, "_idle_ready"}, {31'h0, ordy[0]}, 32'h1);
      check({nm, "_idle_valid"}, {31'h0, oval[0]}, 32'h0);
   endtask

   task automatic rand_ops(input int k, input int nops);
      int n;
      for (int i = 0; i < nops; i++) begin
         repeat ($urandom_range(0, 3)) wait_edge();
         send(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
         // Operand noise while busy must not disturb the result.
         opa[k] = 16'($urandom);
         opb[k] = 16'($urandom);
         cinv[k] = 1'($urandom_range(0, 1));
      end
      n = 0;
      while (!ordy[k] && n < 200) begin
         wait_edge();
         n++;
      end
      check($sformatf("d%0d_drain", k), {31'h0, ordy[k]}, 32'h1);
   endtask

   task automatic rand_ready(input int k);
      while (!rdone[k]) begin
         irdy[k] = ($urandom_range(0, 3) != 0);
         wait_edge();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int k = 0; k < 3; k++) begin
         vin[k] = 1'b0; cinv[k] = 1'b0; irdy[k] = 1'b0;
         opa[k] = '0; opb[k] = '0; rdone[k] = 1'b0;
         active[k] = 1'b0; due[k] = 0; expv[k] = '0;
      end
      arst = 1'b1;
      repeat (2) wait_edge();
      check("reset_ready", {31'h0, ordy[0]}, 32'h1);
      check("reset_valid", {31'h0, oval[0]}, 32'h0);
      check("reset_sum", {16'h0, osum[0]}, 32'h0);
      check("reset_cout", {31'h0, ocout[0]}, 32'h0);
      arst = 1'b0;
      wait_edge();

      dir_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      dir_op("cin",    16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
      dir_op("max",    16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

      // Backpressure with new operands offered during DONE.
      send(0, 16'h1111, 16'h2222, 1'b0);
      wait_valid(0, n);
      check("bp_first_sum", {16'h0, osum[0]}, 32'h3333);
      opa[0] = 16'hAAAA; opb[0] = 16'h5555; cinv[0] = 1'b1; vin[0] = 1'b1;
      repeat (5) begin
         wait_edge();
         check("bp_hold_sum", {16'h0, osum[0]}, 32'h3333);
         check("bp_hold_cout", {31'h0, ocout[0]}, 32'h0);
         check("bp_hold_ready", {31'h0, ordy[0]}, 32'h0);
         check("bp_hold_valid", {31'h0, oval[0]}, 32'h1);
      end
      irdy[0] = 1'b1;
      wait_edge();
      irdy[0] = 1'b0;
      check("bp_release_ready", {31'h0, ordy[0]}, 32'h1);
      check("bp_release_valid", {31'h0, oval[0]}, 32'h0);
      opa[0] = 16'h0F0F; opb[0] = 16'h0101; cinv[0] = 1'b0;
      wait_edge();
      vin[0] = 1'b0;
      check("bp_accept_busy", {31'h0, ordy[0]}, 32'h0);
      wait_valid(0, n);
      check("bp_second_latency", n, 8);
      check("bp_second_sum", {16'h0, osum[0]}, 32'h1010);
      check("bp_second_cout", {31'h0, ocout[0]}, 32'h0);
      irdy[0] = 1'b1;
      wait_edge();
      irdy[0] = 1'b0;

      // Reset while the counter sits at digit 3.
      send(0, 16'h1234, 16'h1111, 1'b0);
      repeat (2) wait_edge();
      arst = 1'b1;
      #1;
      check("midrst_ready", {31'h0, ordy[0]}, 32'h1);
      check("midrst_valid", {31'h0, oval[0]}, 32'h0);
      check("midrst_sum", {16'h0, osum[0]}, 32'h0);
      check("midrst_cout", {31'h0, ocout[0]}, 32'h0);
      wait_edge();
      arst = 1'b0;
      wait_edge();
      dir_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

      fork
         begin rand_ops(0, 1000); rdone[0] = 1'b1; end
         rand_ready(0);
         begin rand_ops(1, 1000); rdone[1] = 1'b1; end
         rand_ready(1);
         begin rand_ops(2, 1000); rdone[2] = 1'b1; end
         rand_ready(2);
      join

      repeat (3) wait_edge();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Digit-serial adder controller. Accepts two DATA_WIDTH-bit operands plus carry-in through a valid/ready handshake. Adds them LSB-first, one DIGIT_WIDTH-bit digit per cycle, through a single full_adder instance, holding the carry between digits. Returns the assembled sum and carry-out through a valid/ready handshake. Sits upstream of full_adder, driving its digit inputs and consuming its digit outputs; used as the accumulate stage behind the serial multiplier in the conv datapath.

Parameters:
- DATA_WIDTH, 16, operand and sum width in bits; must be a multiple of DIGIT_WIDTH.
- DIGIT_WIDTH, 2, bits added per cycle; equals the full_adder width.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_arst  input  1  asynchronous reset, active-high.
- i_valid  input  1  operands and carry-in are valid.
- o_ready  output  1  block can accept operands.
- i_operand1  input  DATA_WIDTH  first addend.
- i_operand2  input  DATA_WIDTH  second addend.
- i_cin  input  1  carry-in to the least-significant digit.
- o_valid  output  1  o_sum and o_cout are valid.
- i_ready  input  1  downstream accepts the result.
- o_sum  output  DATA_WIDTH  sum, modulo 2^DATA_WIDTH.
- o_cout  output  1  carry out of the most-significant digit.

Behaviour:
- NUM_DIGITS = DATA_WIDTH/DIGIT_WIDTH. Elaboration fails if DATA_WIDTH % DIGIT_WIDTH != 0 or DIGIT_WIDTH < 1.
- Reset (asynchronous assert): state = IDLE; operand shift registers, sum register, carry register and digit counter all = 0. Outputs: o_ready=1, o_valid=0, o_sum=0, o_cout=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1, o_valid=0.
  - On i_valid & o_ready: capture both operands, carry <= i_cin, counter <= 0, go to RUN.
- RUN (o_ready=0, o_valid=0), each cycle:
  - full_adder inputs = low DIGIT_WIDTH bits of each operand register, cin = carry register.
  - Operand registers shift right by DIGIT_WIDTH.
  - Sum register shifts right by DIGIT_WIDTH, inserting the adder sum digit at the MSB end.
  - carry <= adder cout; counter++.
  - On the cycle with counter == NUM_DIGITS-1, go to DONE.
- DONE:
  - o_valid=1; o_sum = sum register; o_cout = carry register.
  - Outputs stay stable while i_ready=0.
  - On i_ready, go to IDLE.
- Latency: accept handshake at edge E. RUN occupies the NUM_DIGITS cycles after E. o_valid is high starting the cycle after edge E+NUM_DIGITS. Minimum occupancy is NUM_DIGITS+2 cycles per operation.
- Inputs are sampled only at accept. i_valid and operand changes during RUN or DONE are ignored, and no accept occurs outside IDLE.
- In DONE, i_ready and i_valid both high: the result completes; the new operands are not accepted until the following IDLE cycle.
- NUM_DIGITS=1: RUN lasts exactly one cycle.
- i_arst during RUN or DONE: the operation is aborted and the result is discarded; the block restarts from IDLE.
- Arithmetic: result = i_operand1 + i_operand2 + i_cin over DATA_WIDTH+1 bits, split as {o_cout, o_sum}.

Decomposition:
- Package digit_serial_pkg holds:
  - state enum t_dsa_state {IDLE, RUN, DONE};
  - default DIGIT_WIDTH constant;
  - a function computing NUM_DIGITS and counter width ($clog2(NUM_DIGITS), minimum 1).
- One sub-module: full_adder, instantiated once with DATA_WIDTH=DIGIT_WIDTH. No other hierarchy.

Test Plan:
- Full carry ripple: 0xFFFF + 0x0001, cin=0 -> after 8 RUN cycles o_valid=1, o_sum=0x0000, o_cout=1.
- Carry-in path: 0x1234 + 0x4321, cin=1 -> o_sum=0x5556, o_cout=0. Maximum case: 0xFFFF + 0xFFFF, cin=1 -> o_sum=0xFFFF, o_cout=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE while i_valid=1 with new operands -> o_sum and o_cout stable, o_ready=0, new operands not captured. Release i_ready -> IDLE next cycle, then accept.
- Reset mid-operation: assert i_arst in RUN at digit 3 -> all outputs 0 and o_ready=1 immediately. A fresh 0x00FF + 0x0001 afterwards gives o_sum=0x0100, o_cout=0.
- Randomized: 1000 operations with random i_valid and i_ready gaps, run at defaults and at DATA_WIDTH=8/DIGIT_WIDTH=4 and DATA_WIDTH=2/DIGIT_WIDTH=2 -> every result matches the scoreboard model; latency is exactly NUM_DIGITS+1 cycles from accept to o_valid.
